laser_shot_ctrl: RTL and testbench
==================================

Name: laser_shot_ctrl

Overview:
Sequencer for the player laser datapath. It turns the raw fire button into a single-cycle `fire` pulse and generates the frame-rate `enable` motion ticks. It holds off motion for a hit-flash interval after a kill, then enforces a cooldown before the next shot. It sits between the input pins and the laser block, and it counts shots fired and hits landed.

Parameters:
MOVE_DIV, 1, frames per laser motion step (1..31)
HIT_FRAMES, 8, frames the laser stays frozen after a kill (1..31)
COOLDOWN_FRAMES, 15, frames after flight or hit before re-arm (0..31)
CNT_W, 8, width of shot/hit counters

Ports:
clk  input  1  pixel clock
reset  input  1  asynchronous, active-low reset; all state clears immediately on assertion, release is synchronous to clk
gameActive  input  1  game running; low forces the controller idle
fireBtn  input  1  raw asynchronous fire button, active-high
killingAlien  input  1  laser currently overlaps an alien
yLaser  input  10  laser vertical position; 0 means no laser present
hPos  input  10  VGA horizontal counter
vPos  input  10  VGA vertical counter
fire  output  1  one-cycle fire request to the laser block
enable  output  1  one-cycle motion tick to the laser block
busy  output  1  high in every state except IDLE
shotCount  output  CNT_W  shots fired, wraps
hitCount  output  CNT_W  kills, wraps
state  output  3  current state encoding, for debug and HUD

Behaviour:
- All outputs are registered. Reset values: fire=0, enable=0, busy=0, shotCount=0, hitCount=0, state=IDLE; frame counter and synchronizers cleared.
- frameStart = (hPos==0 && vPos==0), giving one cycle per frame.
- Button path: 2-flop synchronizer, then a rising-edge detect against a third flop. A held button produces exactly one edge.
- States: IDLE=0, FIRE=1, FLYING=2, HIT=3, COOLDOWN=4.
- IDLE: on a button edge with gameActive=1, go to FIRE.
- Latency: fire is high for exactly one cycle, starting at the 3rd rising edge counting the first edge that samples fireBtn=1.
- FIRE (one cycle): fire=1, shotCount+1, frame counter cleared, then go to FLYING.
- FLYING:
  - On each frameStart the frame counter increments.
  - When the counter reaches MOVE_DIV-1, enable=1 for that cycle and the counter clears.
  - killingAlien=1 → HIT; hitCount+1; counter cleared; no enable that cycle, even if frameStart.
  - Otherwise yLaser==0 → COOLDOWN.
  - If killingAlien and yLaser==0 occur in the same cycle, the kill wins.
- HIT: enable held 0. Count HIT_FRAMES frameStarts, then go to COOLDOWN with the counter cleared. killingAlien in this state is ignored (no further hit counting).
- COOLDOWN: count COOLDOWN_FRAMES frameStarts, then go to IDLE. With COOLDOWN_FRAMES=0, go to IDLE on the next cycle.
- gameActive=0: from any state, go to IDLE on the next edge. fire and enable are forced 0, frame counter and pending fire cleared. Counters are held, not cleared.
- Counter arithmetic: shotCount and hitCount are modulo 2^CNT_W. The frame counter is 5 bits and never exceeds max(parameter)-1.
- Asserting reset mid-flight aborts immediately. The laser block is reset separately.

Optional Feature:
Macro: LASER_FIRE_BUFFER_EN.
- Defined: one pending-fire flag is set by a button edge in FIRE, FLYING, HIT or COOLDOWN. On entering IDLE with the flag set, go straight to FIRE on the next edge and clear the flag. Further edges while the flag is set are dropped.
- Undefined: button edges outside IDLE are discarded; no pending flag exists.

Decomposition:
- Package laser_pkg holds:
  - the state typedef and encodings;
  - the screen constants SCREEN_WIDTH=640, SCREEN_HEIGHT=480, SHIP_HEIGHT=30, V_OFFSET=10;
  - the color codes BACKGROUND=0, LASER=3, HIT=1.
- One sub-module: btn_edge_sync, the 2-flop synchronizer plus rising-edge detector, with async active-low reset.

Test Plan:
- Button press at cycle 10, held 50 cycles, gameActive=1 → fire high only in cycle 12, shotCount=1, state=FLYING.
- MOVE_DIV=2, laser flying for 6 frameStarts → exactly 3 enable pulses, each coincident with an even frameStart.
- killingAlien pulse during FLYING → hitCount=1, no enable for 8 frameStarts, then COOLDOWN for 15 frameStarts, then IDLE.
- killingAlien and yLaser==0 in the same cycle → HIT taken, hitCount+1.
- Button press during COOLDOWN:
  - without LASER_FIRE_BUFFER_EN → no fire;
  - with LASER_FIRE_BUFFER_EN → fire one cycle after entering IDLE, shotCount=2.
- gameActive dropped mid-FLYING, then reset asserted asynchronously mid-HIT:
  - gameActive drop → IDLE next cycle, counters kept;
  - reset → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/laser_pkg.sv
`default_nettype none
// ---- laser_pkg: shared state encodings, screen geometry and colour codes (rev 1.0) ----
package laser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FIRE     = 3'd1,
    ST_FLYING   = 3'd2,
    ST_HIT      = 3'd3,
    ST_COOLDOWN = 3'd4
  } laser_state_t;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int SHIP_HEIGHT   = 30;
  localparam int V_OFFSET      = 10;

  localparam logic [1:0] BACKGROUND = 2'd0;
  localparam logic [1:0] LASER      = 2'd3;
  localparam logic [1:0] HIT        = 2'd1;

endpackage : laser_pkg
`default_nettype wire

// File: rtl/btn_edge_sync.sv
`default_nettype none
// ---- btn_edge_sync: 2-flop synchronizer plus rising-edge detect on a raw button (rev 1.0) ----
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  // sync[0], sync[1] form the synchronizer; sync[2] holds the previous synced level
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[1:0], btn};
  end

  assign rise = sync[1] & ~sync[2];

endmodule : btn_edge_sync
`default_nettype wire

// File: rtl/laser_shot_ctrl.sv
`default_nettype none
// ---- laser_shot_ctrl: fire/motion sequencer for the player laser (rev 1.0) ----
// ---- Optional macro LASER_FIRE_BUFFER_EN buffers one fire press made while busy. ----
module laser_shot_ctrl
  import laser_pkg::*;
#(
  parameter int MOVE_DIV        = 1,
  parameter int HIT_FRAMES      = 8,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gameActive,
  input  logic             fireBtn,
  input  logic             killingAlien,
  input  logic [9:0]       yLaser,
  input  logic [9:0]       hPos,
  input  logic [9:0]       vPos,
  output logic             fire,
  output logic             enable,
  output logic             busy,
  output logic [CNT_W-1:0] shotCount,
  output logic [CNT_W-1:0] hitCount,
  output logic [2:0]       state
);

  localparam logic [4:0] MOVE_LAST = 5'(MOVE_DIV - 1);
  localparam logic [4:0] HIT_LAST  = 5'(HIT_FRAMES - 1);
  localparam logic [4:0] COOL_LAST = (COOLDOWN_FRAMES == 0) ? 5'd0 : 5'(COOLDOWN_FRAMES - 1);

  laser_state_t     state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             fire_d, enable_d;
  logic [CNT_W-1:0] shot_d, hit_d;
  logic             btn_rise;
  logic             frame_start;
  logic             pend_q;
  logic             launch;

  btn_edge_sync u_btn_sync (
    .clk   (clk),
    .rst_n (reset),
    .btn   (fireBtn),
    .rise  (btn_rise)
  );

  assign frame_start = (hPos == 10'd0) && (vPos == 10'd0);
  assign launch      = gameActive && (state_q == ST_IDLE) && (btn_rise || pend_q);

`ifdef LASER_FIRE_BUFFER_EN
  logic pend_d;

  always_comb begin
    pend_d = pend_q;
    if (!gameActive || launch)                    pend_d = 1'b0;
    else if (btn_rise && (state_q != ST_IDLE))    pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end
`else
  assign pend_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fire      <= 1'b0;
      enable    <= 1'b0;
      busy      <= 1'b0;
      shotCount <= '0;
      hitCount  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fire      <= fire_d;
      enable    <= enable_d;
      busy      <= (state_d != ST_IDLE);
      shotCount <= shot_d;
      hitCount  <= hit_d;
    end
  end

  assign state = state_q;

  // Outputs are computed for the state being entered so they register alongside it
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fire_d   = 1'b0;
    enable_d = 1'b0;
    shot_d   = shotCount;
    hit_d    = hitCount;
    if (!gameActive) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            state_d = ST_FIRE;
            fire_d  = 1'b1;
            shot_d  = shotCount + CNT_W'(1);
            cnt_d   = '0;
          end
        end
        ST_FIRE: state_d = ST_FLYING;
        ST_FLYING: begin
          if (killingAlien) begin
            state_d = ST_HIT;
            hit_d   = hitCount + CNT_W'(1);
            cnt_d   = '0;
          end else if (yLaser == 10'd0) begin
            state_d = ST_COOLDOWN;
            cnt_d   = '0;
          end else if (frame_start) begin
            if (cnt_q == MOVE_LAST) begin
              enable_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        ST_HIT: begin
          if (frame_start) begin
            if (cnt_q == HIT_LAST) begin
              state_d = ST_COOLDOWN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (COOLDOWN_FRAMES == 0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (frame_start) begin
            if (cnt_q == COOL_LAST) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule : laser_shot_ctrl
`default_nettype wire

// File: tb/tb_laser_shot_ctrl.sv
`default_nettype none
// ---- tb_laser_shot_ctrl: directed self-checking bench for laser_shot_ctrl (rev 1.0) ----
module tb_laser_shot_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       gameActive, fireBtn, killingAlien;
  logic [9:0] yLaser, hPos, vPos;
  logic       fire, enable, busy;
  logic [7:0] shotCount, hitCount;
  logic [2:0] state;

  int vectors = 0;
  int errors  = 0;
  int exp_shots = 0;
  int exp_hits  = 0;

  laser_shot_ctrl #(
    .MOVE_DIV(2), .HIT_FRAMES(8), .COOLDOWN_FRAMES(15), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .gameActive(gameActive), .fireBtn(fireBtn),
    .killingAlien(killingAlien), .yLaser(yLaser), .hPos(hPos), .vPos(vPos),
    .fire(fire), .enable(enable), .busy(busy), .shotCount(shotCount),
    .hitCount(hitCount), .state(state)
  );

  always #5 clk = ~clk;

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_pulse();
    hPos = 10'd0; vPos = 10'd0;
    @(posedge clk);
    #1;
    hPos = 10'd5; vPos = 10'd5;
  endtask

  task automatic press(input int hold, input string tag);
    int pulses;
    pulses = 0;
    fireBtn = 1'b1;
    for (int k = 1; k <= hold + 3; k++) begin
      if (k == hold + 1) fireBtn = 1'b0;
      @(posedge clk);
      #1;
      if (fire === 1'b1) pulses++;
      vectors++;
      if (fire !== (k == 3)) begin
        errors++;
        $display("FAIL %s fire@edge%0d: got %b want %b", tag, k, fire, (k == 3));
      end
    end
    exp_shots++;
    vectors++;
    if (pulses != 1 || shotCount !== 8'(exp_shots) || state !== 3'd2) begin
      errors++;
      $display("FAIL %s result: pulses %0d shot %0d state %0d want 1 %0d 2",
               tag, pulses, shotCount, state, exp_shots);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({fire, enable, busy} !== 3'b000 || shotCount !== 8'd0 || hitCount !== 8'd0 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: got f%b e%b b%b s%0d h%0d st%0d want all 0",
               fire, enable, busy, shotCount, hitCount, state);
    end
    @(negedge clk);
    reset = 1'b1;
    cycle(2);
    vectors++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got st%0d b%b want 0 0", state, busy);
    end
  endtask

  task automatic test_fire_latency();
    cycle(10);
    press(50, "fire_latency");
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_flying: got %b want 1", busy);
    end
  endtask

  task automatic test_enable();
    int pulses;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      frame_pulse();
      if (enable === 1'b1) pulses++;
      vectors++;
      if (enable !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL enable_frame%0d: got %b want %b", i, enable, ((i % 2) == 0));
      end
      cycle(1);
      vectors++;
      if (enable !== 1'b0) begin
        errors++;
        $display("FAIL enable_width%0d: got %b want 0", i, enable);
      end
      cycle(1);
    end
    vectors++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL enable_count: got %0d want 3", pulses);
    end
  endtask

  task automatic test_hit();
    killingAlien = 1'b1;
    frame_pulse();
    killingAlien = 1'b0;
    exp_hits++;
    vectors++;
    if (state !== 3'd3 || hitCount !== 8'(exp_hits) || enable !== 1'b0) begin
      errors++;
      $display("FAIL hit_entry: got st%0d h%0d e%b want 3 %0d 0", state, hitCount, enable, exp_hits);
    end
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) killingAlien = 1'b1;
      frame_pulse();
      killingAlien = 1'b0;
      vectors++;
      if (state !== ((k < 8) ? 3'd3 : 3'd4) || enable !== 1'b0 || hitCount !== 8'(exp_hits)) begin
        errors++;
        $display("FAIL hit_frame%0d: got st%0d e%b h%0d want %0d 0 %0d",
                 k, state, enable, hitCount, (k < 8) ? 3 : 4, exp_hits);
      end
      cycle(2);
    end
    for (int k = 1; k <= 15; k++) begin
      frame_pulse();
      vectors++;
      if (state !== ((k < 15) ? 3'd4 : 3'd0) || busy !== (k < 15)) begin
        errors++;
        $display("FAIL cooldown_frame%0d: got st%0d b%b want %0d %b",
                 k, state, busy, (k < 15) ? 4 : 0, (k < 15));
      end
      cycle(1);
    end
  endtask

  task automatic test_cooldown_press();
    press(4, "refire");
    yLaser = 10'd0;
    cycle(1);
    yLaser = 10'd100;
    vectors++;
    if (state !== 3'd4) begin
      errors++;
      $display("FAIL empty_to_cooldown: got %0d want 4", state);
    end
    fireBtn = 1'b1;
    cycle(3);
    fireBtn = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      frame_pulse();
      vectors++;
      if (fire !== 1'b0) begin
        errors++;
        $display("FAIL cooldown_no_fire%0d: got %b want 0", k, fire);
      end
    end
    vectors++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL cooldown_exit: got %0d want 0", state);
    end
`ifdef LASER_FIRE_BUFFER_EN
    cycle(1);
    exp_shots++;
    vectors++;
    if (fire !== 1'b1 || state !== 3'd1 || shotCount !== 8'(exp_shots)) begin
      errors++;
      $display("FAIL buffered_fire: got f%b st%0d s%0d want 1 1 %0d", fire, state, shotCount, exp_shots);
    end
    cycle(1);
    vectors++;
    if (fire !== 1'b0 || state !== 3'd2) begin
      errors++;
      $display("FAIL buffered_after: got f%b st%0d want 0 2", fire, state);
    end
`else
    for (int k = 1; k <= 5; k++) begin
      cycle(1);
      vectors++;
      if (fire !== 1'b0 || state !== 3'd0 || shotCount !== 8'(exp_shots)) begin
        errors++;
        $display("FAIL dropped_press%0d: got f%b st%0d s%0d want 0 0 %0d", k, fire, state, shotCount, exp_shots);
      end
    end
    press(4, "refire_idle");
`endif
  endtask

  task automatic test_game_inactive();
    gameActive = 1'b0;
    cycle(1);
    vectors++;
    if (state !== 3'd0 || busy !== 1'b0 || fire !== 1'b0 || enable !== 1'b0 ||
        shotCount !== 8'(exp_shots) || hitCount !== 8'(exp_hits)) begin
      errors++;
      $display("FAIL game_off: got st%0d b%b s%0d h%0d want 0 0 %0d %0d",
               state, busy, shotCount, hitCount, exp_shots, exp_hits);
    end
    gameActive = 1'b1;
    cycle(2);
  endtask

  task automatic test_kill_and_empty();
    press(4, "fire_again");
    killingAlien = 1'b1;
    yLaser = 10'd0;
    cycle(1);
    killingAlien = 1'b0;
    yLaser = 10'd100;
    exp_hits++;
    vectors++;
    if (state !== 3'd3 || hitCount !== 8'(exp_hits)) begin
      errors++;
      $display("FAIL kill_wins: got st%0d h%0d want 3 %0d", state, hitCount, exp_hits);
    end
  endtask

  task automatic test_async_reset();
    cycle(2);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({fire, enable, busy} !== 3'b000 || shotCount !== 8'd0 || hitCount !== 8'd0 || state !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: got f%b e%b b%b s%0d h%0d st%0d want all 0",
               fire, enable, busy, shotCount, hitCount, state);
    end
    @(negedge clk);
    reset = 1'b1;
    cycle(2);
    vectors++;
    if (state !== 3'd0 || shotCount !== 8'd0) begin
      errors++;
      $display("FAIL post_reset: got st%0d s%0d want 0 0", state, shotCount);
    end
  endtask

  initial begin
    reset = 1'b0; gameActive = 1'b1; fireBtn = 1'b0; killingAlien = 1'b0;
    yLaser = 10'd100; hPos = 10'd5; vPos = 10'd5;
    #12;
    test_reset();
    test_fire_latency();
    test_enable();
    test_hit();
    test_cooldown_press();
    test_game_inactive();
    test_kill_and_empty();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_laser_shot_ctrl
`default_nettype wire
